// File: rtl/mul_ds.sv
// Digit-serial unsigned multiplier: C = a * b, consuming D bits of b per cycle.
// The modulus high part qH travels alongside the operands so the downstream
// Montgomery reduction stage receives C and qH together on one valid/ready beat.
module mul_ds #(
    parameter int LOGQ  = 32,
    parameter int LOGQH = 19,
    parameter int D     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LOGQ-1:0]      a,
    input  logic [LOGQ-1:0]      b,
    input  logic [LOGQH-1:0]     qH_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*LOGQ-1:0]    C,
    output logic [LOGQH-1:0]     qH_out
);

    // Number of digit steps; the top digit may be partially filled (b is zero-extended).
    localparam int ITER = (LOGQ + D - 1) / D;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int BW   = ITER * D;
    localparam int PW   = 2 * LOGQ;
    localparam int SW   = $clog2(PW) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic [LOGQ-1:0]      a_r;
    logic [BW-1:0]        b_r;
    logic [PW-1:0]        acc_r;
    logic [CW-1:0]        cnt_r;
    logic [LOGQH-1:0]     qH_r;
    logic                 out_valid_r;

    logic                 accept_s;
    logic [LOGQ+D-1:0]    pp_s;
    logic [SW-1:0]        shamt_s;
    logic [PW-1:0]        acc_next_s;

    // A new pair can enter when idle, or when the finished result leaves on this edge.
    assign in_ready = (state_r == IDLE) | ((state_r == DONE) & out_ready);
    assign accept_s = in_valid & in_ready;

    // One digit step: partial product of a with the low digit of b, aligned by digit index.
    // Bits pushed past 2*LOGQ are zero for any legal product and are dropped.
    always_comb begin
        pp_s       = {{D{1'b0}}, a_r} * {{LOGQ{1'b0}}, b_r[D-1:0]};
        shamt_s    = SW'(cnt_r) * SW'(D);
        acc_next_s = acc_r + (PW'(pp_s) << shamt_s);
    end

    // Control FSM and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            acc_r       <= '0;
            cnt_r       <= '0;
            qH_r        <= '0;
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            a_r         <= a;
            b_r         <= BW'(b);
            qH_r        <= qH_in;
            acc_r       <= '0;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            state_r     <= BUSY;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
                BUSY: begin
                    acc_r <= acc_next_s;
                    b_r   <= b_r >> D;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CW'(ITER - 1)) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r     <= BUSY;
                        out_valid_r <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Result outputs come straight from registers.
    assign out_valid = out_valid_r;
    assign C         = acc_r;
    assign qH_out    = qH_r;

endmodule
